pio_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer for the OCIDEC PIO transfer port
//  (PIOreq/PIOack/PIOa/PIOd/PIOq/PIOwe) of the IDE controller.
//  - Shares the single PIO port between two host-side masters using round-robin.
//  - Frames each access with the req/ack handshake the controller expects.
//  - Enforces a request-low recovery gap so every access produces a fresh start pulse.
//  - Aborts accesses the controller never acknowledges.

---
 rtl/pio_arbiter.sv | 127 ++++++++++++
 tb/tb_pio_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_arbiter.sv
// Round-robin arbiter and req/ack sequencer sharing one OCIDEC PIO port between two masters.
// Accesses the controller never acknowledges are aborted after TIMEOUT cycles and flagged with err.
module pio_arbiter #(
  parameter int unsigned TOWIDTH = 16,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned RECOV   = 2
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [7:0]  a,
  input  logic [31:0] d,
  output logic [1:0]  ack,
  output logic [1:0]  err,
  output logic [15:0] q,
  output logic [1:0]  gnt,
  output logic        PIOreq,
  input  logic        PIOack,
  output logic [3:0]  PIOa,
  output logic [15:0] PIOd,
  input  logic [15:0] PIOq,
  output logic        PIOwe
);

  typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

  localparam logic [TOWIDTH-1:0] ToLast    = TOWIDTH'(TIMEOUT - 1);
  localparam logic [TOWIDTH-1:0] RecovLast = TOWIDTH'(RECOV - 1);

  state_e               state_q, state_d;
  logic [TOWIDTH-1:0]   cnt_q, cnt_d;
  logic                 ptr_q, ptr_d;  // 1 = master 1 preferred on contention
  logic [1:0]           ack_d, err_d, gnt_d;
  logic [15:0]          q_d, piod_d;
  logic [3:0]           pioa_d;
  logic                 pioreq_d, piowe_d;
  logic                 sel;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      ack     <= '0;
      err     <= '0;
      q       <= '0;
      gnt     <= '0;
      PIOreq  <= 1'b0;
      PIOa    <= '0;
      PIOd    <= '0;
      PIOwe   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ack     <= ack_d;
      err     <= err_d;
      q       <= q_d;
      gnt     <= gnt_d;
      PIOreq  <= pioreq_d;
      PIOa    <= pioa_d;
      PIOd    <= piod_d;
      PIOwe   <= piowe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    err_d    = '0;
    q_d      = q;
    gnt_d    = gnt;
    pioreq_d = PIOreq;
    pioa_d   = PIOa;
    piod_d   = PIOd;
    piowe_d  = PIOwe;
    sel      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          sel      = (req == 2'b11) ? ptr_q : req[1];
          gnt_d    = sel ? 2'b10 : 2'b01;
          pioa_d   = sel ? a[7:4] : a[3:0];
          piod_d   = sel ? d[31:16] : d[15:0];
          piowe_d  = sel ? we[1] : we[0];
          pioreq_d = 1'b1;
          cnt_d    = '0;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // A real ack on the timeout cycle takes priority over the abort.
        if (PIOack) begin
          q_d      = PIOq;
          ack_d    = gnt;
          pioreq_d = 1'b0;
          gnt_d    = '0;
          ptr_d    = gnt[0];
          cnt_d    = '0;
          state_d  = StRecover;
        end else if ((TIMEOUT != 0) && (cnt_q == ToLast)) begin
          ack_d    = gnt;
          err_d    = gnt;
          pioreq_d = 1'b0;
          gnt_d    = '0;
          ptr_d    = gnt[0];
          cnt_d    = '0;
          state_d  = StRecover;
        end
      end
      StRecover: begin
        if (cnt_q == RecovLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_pio_arbiter.sv
// Directed bench for pio_arbiter: dut0 uses the default timeout, dut1 uses TIMEOUT=8.
module tb_pio_arbiter;

  logic        clk = 1'b0;
  logic        nreset;
  logic [1:0]  req, we;
  logic [7:0]  a;
  logic [31:0] d;
  logic [15:0] pioq;
  logic        pioack0, pioack1;

  logic [1:0]  ack0, err0, gnt0, ack1, err1, gnt1;
  logic [15:0] q0, piod0, q1, piod1;
  logic [3:0]  pioa0, pioa1;
  logic        pioreq0, piowe0, pioreq1, piowe1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pio_arbiter dut0 (
    .clk(clk), .nReset(nreset), .req(req), .we(we), .a(a), .d(d),
    .ack(ack0), .err(err0), .q(q0), .gnt(gnt0),
    .PIOreq(pioreq0), .PIOack(pioack0), .PIOa(pioa0), .PIOd(piod0), .PIOq(pioq), .PIOwe(piowe0)
  );

  pio_arbiter #(.TIMEOUT(8)) dut1 (
    .clk(clk), .nReset(nreset), .req(req), .we(we), .a(a), .d(d),
    .ack(ack1), .err(err1), .q(q1), .gnt(gnt1),
    .PIOreq(pioreq1), .PIOack(pioack1), .PIOa(pioa1), .PIOd(piod1), .PIOq(pioq), .PIOwe(piowe1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0; req = '0; we = '0; a = '0; d = '0; pioq = '0;
    pioack0 = 1'b0; pioack1 = 1'b0;
    tick();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ack0, err0, gnt0, pioreq0, piowe0, pioa0} !== 11'd0 || q0 !== 16'd0 || piod0 !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs got ack=%b err=%b gnt=%b req=%b q=%h d=%h exp all zero",
               ack0, err0, gnt0, pioreq0, q0, piod0);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req = 2'b01; a = 8'h07;
    tick();
    total++;
    if (pioreq0 !== 1'b1 || gnt0 !== 2'b01 || pioa0 !== 4'h7 || piowe0 !== 1'b0) begin
      bad++;
      $display("FAIL read_grant got req=%b gnt=%b a=%h we=%b exp 1 01 7 0", pioreq0, gnt0, pioa0, piowe0);
    end
    for (int i = 0; i < 9; i++) tick();
    total++;
    if (ack0 !== 2'b00 || pioreq0 !== 1'b1) begin
      bad++;
      $display("FAIL read_wait got ack=%b req=%b exp 00 1", ack0, pioreq0);
    end
    pioack0 = 1'b1; pioq = 16'hBEEF;
    tick();
    pioack0 = 1'b0; req = 2'b00;
    total++;
    if (ack0 !== 2'b01 || err0 !== 2'b00 || q0 !== 16'hBEEF || pioreq0 !== 1'b0 || gnt0 !== 2'b00) begin
      bad++;
      $display("FAIL read_done got ack=%b err=%b q=%h req=%b gnt=%b exp 01 00 beef 0 00",
               ack0, err0, q0, pioreq0, gnt0);
    end
    tick();
    total++;
    if (ack0 !== 2'b00 || pioreq0 !== 1'b0 || q0 !== 16'hBEEF) begin
      bad++;
      $display("FAIL read_recover got ack=%b req=%b q=%h exp 00 0 beef", ack0, pioreq0, q0);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    int n;
    do_reset();
    req = 2'b11; a = 8'h52; d = 32'hB0B1_A0A0; we = 2'b00;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      for (int k = 0; k < 10 && !pioreq0; k++) begin
        tick();
        n++;
      end
      total++;
      if (pioreq0 !== 1'b1 || gnt0 !== exp_g) begin
        bad++;
        $display("FAIL contend_gnt%0d got req=%b gnt=%b exp 1 %b", i, pioreq0, gnt0, exp_g);
      end
      total++;
      if (pioa0 !== (exp_g[1] ? 4'h5 : 4'h2) || piod0 !== (exp_g[1] ? 16'hB0B1 : 16'hA0A0)) begin
        bad++;
        $display("FAIL contend_data%0d got a=%h d=%h", i, pioa0, piod0);
      end
      if (i > 0) begin
        total++;
        if (n !== 3) begin
          bad++;
          $display("FAIL back_to_back%0d got gap=%0d exp 3", i, n);
        end
      end
      tick();
      pioack0 = 1'b1;
      tick();
      pioack0 = 1'b0;
      total++;
      if (ack0 !== exp_g || err0 !== 2'b00) begin
        bad++;
        $display("FAIL contend_ack%0d got ack=%b err=%b exp %b 00", i, ack0, err0, exp_g);
      end
    end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 2'b01; a = 8'h90;
    tick();
    pioack1 = 1'b1; pioq = 16'hCAFE;
    tick();
    pioack1 = 1'b0; req = 2'b00;
    total++;
    if (ack1 !== 2'b01 || q1 !== 16'hCAFE) begin
      bad++;
      $display("FAIL timeout_prep got ack=%b q=%h exp 01 cafe", ack1, q1);
    end
    tick(); tick();
    req = 2'b10;
    tick();
    for (int c = 1; c < 9; c++) begin
      total++;
      if (ack1 !== 2'b00 || pioreq1 !== 1'b1 || gnt1 !== 2'b10) begin
        bad++;
        $display("FAIL timeout_wait%0d got ack=%b req=%b gnt=%b exp 00 1 10", c, ack1, pioreq1, gnt1);
      end
      tick();
    end
    total++;
    if (ack1 !== 2'b10 || err1 !== 2'b10 || q1 !== 16'hCAFE || pioreq1 !== 1'b0) begin
      bad++;
      $display("FAIL timeout_abort got ack=%b err=%b q=%h req=%b exp 10 10 cafe 0",
               ack1, err1, q1, pioreq1);
    end
    req = 2'b00; pioack1 = 1'b1; pioq = 16'h5555;
    tick();
    pioack1 = 1'b0;
    total++;
    if (ack1 !== 2'b00 || err1 !== 2'b00 || q1 !== 16'hCAFE) begin
      bad++;
      $display("FAIL late_ack got ack=%b err=%b q=%h exp 00 00 cafe", ack1, err1, q1);
    end
    tick(); tick();
  endtask

  task automatic test_boundary();
    req = 2'b10; a = 8'hA0;
    tick();
    for (int c = 1; c < 8; c++) tick();
    total++;
    if (pioreq1 !== 1'b1 || ack1 !== 2'b00) begin
      bad++;
      $display("FAIL boundary_wait got req=%b ack=%b exp 1 00", pioreq1, ack1);
    end
    pioack1 = 1'b1; pioq = 16'h1357;
    tick();
    pioack1 = 1'b0; req = 2'b00;
    total++;
    if (ack1 !== 2'b10 || err1 !== 2'b00 || q1 !== 16'h1357) begin
      bad++;
      $display("FAIL boundary_ack got ack=%b err=%b q=%h exp 10 00 1357", ack1, err1, q1);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    req = 2'b01; a = 8'h03;
    tick(); tick();
    pioack0 = 1'b1; pioq = 16'hABCD;
    tick();
    pioack0 = 1'b0;
    tick(); tick(); tick();
    total++;
    if (pioreq0 !== 1'b1 || q0 !== 16'hABCD) begin
      bad++;
      $display("FAIL midreset_setup got req=%b q=%h exp 1 abcd", pioreq0, q0);
    end
    req = 2'b00; nreset = 1'b0;
    tick();
    total++;
    if (pioreq0 !== 1'b0 || gnt0 !== 2'b00 || ack0 !== 2'b00 || err0 !== 2'b00 || q0 !== 16'd0) begin
      bad++;
      $display("FAIL midreset_clear got req=%b gnt=%b ack=%b q=%h exp 0 00 00 0000",
               pioreq0, gnt0, ack0, q0);
    end
    nreset = 1'b1; req = 2'b10; a = 8'hE0;
    tick();
    total++;
    if (pioreq0 !== 1'b1 || gnt0 !== 2'b10 || pioa0 !== 4'hE) begin
      bad++;
      $display("FAIL midreset_m1 got req=%b gnt=%b a=%h exp 1 10 e", pioreq0, gnt0, pioa0);
    end
    pioack0 = 1'b1;
    tick();
    pioack0 = 1'b0; req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_write_path();
    do_reset();
    req = 2'b10; we = 2'b10; a = 8'hC0; d = 32'h1234_0000;
    tick();
    req = 2'b00; we = 2'b00; a = 8'h00; d = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (piowe0 !== 1'b1 || piod0 !== 16'h1234 || pioa0 !== 4'hC || pioreq0 !== 1'b1) begin
        bad++;
        $display("FAIL write_hold%0d got we=%b d=%h a=%h req=%b exp 1 1234 c 1",
                 c, piowe0, piod0, pioa0, pioreq0);
      end
      tick();
    end
    pioack0 = 1'b1; pioq = 16'h0F0F;
    tick();
    pioack0 = 1'b0;
    total++;
    if (ack0 !== 2'b10 || err0 !== 2'b00 || q0 !== 16'h0F0F) begin
      bad++;
      $display("FAIL write_ack got ack=%b err=%b q=%h exp 10 00 0f0f", ack0, err0, q0);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_boundary();
    test_reset_mid_access();
    test_write_path();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
